// File: rtl/gpu_copy_sched_if.sv
// Purpose : bundles the scheduler's frame-timing, memory-port and GPU-stream
//           signals; master = scheduler, slave = surrounding system/bench.
// Latency : n/a (wires only).  Backpressure: none, the stream is fixed-cadence.
// Ports   : vblank_start/frame_ready (timing, CPU), bus_req/bus_gnt (arbiter),
//           mem_re/mem_addr/mem_rdata (data memory), copy_start/gpu_din/
//           copy_done (GPU), busy/missed_frame/bus_err (status).
interface gpu_copy_sched_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  vblank_start;
  logic                  frame_ready;
  logic                  bus_gnt;
  logic [15:0]           mem_rdata;
  logic                  bus_req;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  copy_start;
  logic [15:0]           gpu_din;
  logic                  busy;
  logic                  copy_done;
  logic                  missed_frame;
  logic                  bus_err;

  modport master (
    input  vblank_start, frame_ready, bus_gnt, mem_rdata,
    output bus_req, mem_re, mem_addr, copy_start, gpu_din,
           busy, copy_done, missed_frame, bus_err
  );

  modport slave (
    output vblank_start, frame_ready, bus_gnt, mem_rdata,
    input  bus_req, mem_re, mem_addr, copy_start, gpu_din,
           busy, copy_done, missed_frame, bus_err
  );
endinterface

// File: rtl/gpu_copy_sched.sv
// Purpose : per-frame copy of the rect table (RECT_COUNT x 5 words) from CPU
//           data memory into the GPU, in a 6-slot-per-rect cadence.
// Latency : START to DONE is 1+6*RECT_COUNT+1 cycles; grant wait <= GNT_TIMEOUT.
// Backpressure: none once granted; a lost grant only raises sticky bus_err.
// Ports   : pixel_clk, reset (async, active-low), bus (gpu_copy_sched_if.master).
module gpu_copy_sched #(
  parameter int                    RECT_COUNT  = 64,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    GNT_TIMEOUT = 255
) (
  input  logic                    pixel_clk,
  input  logic                    reset,
  gpu_copy_sched_if.master        bus
);

  localparam int RW = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
  localparam int TW = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] RECT_LAST = RW'(RECT_COUNT - 1);
  // Last REQ cycle is the GNT_TIMEOUT-th one: counter holds cycles already spent.
  localparam logic [TW-1:0] TMO_LAST  = TW'(GNT_TIMEOUT - 1);
  localparam logic [2:0]    SLOT_LAST = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    START  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmo_cnt_q;
  logic [2:0]            slot_q;
  logic [RW-1:0]         rect_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_vld_q;
  logic                  missed_q;
  logic                  bus_err_q;

  logic                  missed_evt;
  logic                  mem_re;
  logic                  bus_req;
  logic                  copy_start;
  logic                  copy_done;
  logic                  req_timeout;
  logic                  stream_last;

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus_req     = 1'b0;
    mem_re      = 1'b0;
    copy_start  = 1'b0;
    copy_done   = 1'b0;
    req_timeout = 1'b0;
    stream_last = 1'b0;
    missed_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vblank_start) begin
          if (bus.frame_ready) state_d    = REQ;
          else                 missed_evt = 1'b1;
        end
      end
      REQ: begin
        bus_req    = 1'b1;
        missed_evt = bus.vblank_start;
        // Grant takes priority over a timeout in the same cycle.
        if (bus.bus_gnt) begin
          state_d = START;
        end else if (tmo_cnt_q == TMO_LAST) begin
          req_timeout = 1'b1;
          missed_evt  = 1'b1;
          state_d     = IDLE;
        end
      end
      START: begin
        bus_req    = 1'b1;
        copy_start = 1'b1;
        missed_evt = bus.vblank_start;
        state_d    = STREAM;
      end
      STREAM: begin
        bus_req     = 1'b1;
        mem_re      = (slot_q != SLOT_LAST);
        missed_evt  = bus.vblank_start;
        stream_last = (slot_q == SLOT_LAST) && (rect_q == RECT_LAST);
        if (stream_last) state_d = DONE;
      end
      DONE: begin
        copy_done  = 1'b1;
        missed_evt = bus.vblank_start;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant-wait counter: cleared outside REQ, counts REQ cycles without grant.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == REQ && !bus.bus_gnt && !req_timeout) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  // Slot/rect position and running read address; addr only advances on reads
  // so slot 5 leaves it pointing at the next rect's x word.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      rect_q <= '0;
      addr_q <= '0;
    end else if (state_q == START) begin
      slot_q <= '0;
      rect_q <= '0;
      addr_q <= BASE_ADDR;
    end else if (state_q == STREAM) begin
      if (slot_q == SLOT_LAST) begin
        slot_q <= '0;
        rect_q <= rect_q + 1'b1;
      end else begin
        slot_q <= slot_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      rd_vld_q  <= 1'b0;
      missed_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      rd_vld_q <= mem_re;
      missed_q <= missed_evt;
      if ((state_q == START || state_q == STREAM) && !bus.bus_gnt)
        bus_err_q <= 1'b1;
    end
  end

  assign bus.bus_req      = bus_req;
  assign bus.mem_re       = mem_re;
  assign bus.mem_addr     = mem_re ? addr_q : '0;
  assign bus.copy_start   = copy_start;
  // Memory data is one cycle behind mem_re; anything else is forced to zero.
  assign bus.gpu_din      = rd_vld_q ? bus.mem_rdata : 16'd0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.copy_done    = copy_done;
  assign bus.missed_frame = missed_q;
  assign bus.bus_err      = bus_err_q;

endmodule

// File: tb/tb_gpu_copy_sched.sv
module tb_gpu_copy_sched;

  localparam int          RC   = 64;
  localparam logic [15:0] BASE = 16'hFF80;

  logic pixel_clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  gpu_copy_sched_if #(.ADDR_WIDTH(16)) bus ();

  gpu_copy_sched #(
    .RECT_COUNT (RC),
    .ADDR_WIDTH (16),
    .BASE_ADDR  (BASE),
    .GNT_TIMEOUT(255)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h3C5A;
  endfunction

  // Data memory: one-cycle read latency, junk when not reading.
  always @(posedge pixel_clk)
    bus.mem_rdata <= bus.mem_re ? pat(bus.mem_addr) : 16'hDEAD;

  typedef struct {
    logic        re;
    logic [15:0] addr;
    logic [15:0] din;
    logic        err;
    logic        miss;
  } exp_t;

  exp_t sb[$];

  task automatic step();
    @(posedge pixel_clk);
    @(negedge pixel_clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.vblank_start = 1'b0;
    bus.frame_ready  = 1'b0;
    bus.bus_gnt      = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [48:0] outs;
    reset = 1'b0;
    bus.vblank_start = 1'b0;
    bus.frame_ready  = 1'b0;
    bus.bus_gnt      = 1'b0;
    step();
    step();
    outs = {bus.bus_req, bus.mem_re, bus.mem_addr, bus.copy_start, bus.gpu_din,
            bus.busy, bus.copy_done, bus.missed_frame, bus.bus_err};
    n_tests++;
    if (outs !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy got %b want 0", bus.busy);
    end
  endtask

  // Full copy with optional grant drop, stray vblank, or reset abort at S+k.
  task automatic run_copy(input int drop_at, input int vb_at, input int rst_at);
    exp_t        e;
    int          re_cnt;
    logic [15:0] last_addr;
    logic [15:0] a;
    re_cnt    = 0;
    last_addr = 16'h0;
    bus.vblank_start = 1'b1;
    bus.frame_ready  = 1'b1;
    bus.bus_gnt      = 1'b0;
    step();
    bus.vblank_start = 1'b0;
    bus.bus_gnt      = 1'b1;
    n_tests++;
    if (bus.bus_req !== 1'b1 || bus.busy !== 1'b1 || bus.copy_start !== 1'b0) begin
      n_fail++;
      $display("FAIL req_state req=%b busy=%b start=%b want 1 1 0",
               bus.bus_req, bus.busy, bus.copy_start);
    end
    step();
    n_tests++;
    if (bus.copy_start !== 1'b1 || bus.mem_re !== 1'b0 || bus.bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL start_cycle start=%b re=%b req=%b want 1 0 1",
               bus.copy_start, bus.mem_re, bus.bus_req);
    end
    sb.delete();
    for (int r = 0; r < RC; r++) begin
      for (int j = 0; j < 6; j++) begin
        int k;
        k = 1 + 6 * r + j;
        a = BASE + 16'(5 * r + j);
        e.re   = (j < 5);
        e.addr = (j < 5) ? a : 16'h0;
        e.din  = (j == 0) ? 16'h0 : pat(a - 16'd1);
        e.err  = (drop_at > 0) && (k > drop_at);
        e.miss = (vb_at > 0) && (k == vb_at + 1);
        sb.push_back(e);
      end
    end
    for (int k = 1; k <= 6 * RC; k++) begin
      step();
      bus.vblank_start = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if (bus.mem_re !== e.re) begin
        n_fail++;
        $display("FAIL stream_re k=%0d got %b want %b", k, bus.mem_re, e.re);
      end
      n_tests++;
      if (bus.mem_addr !== e.addr) begin
        n_fail++;
        $display("FAIL stream_addr k=%0d got %h want %h", k, bus.mem_addr, e.addr);
      end
      n_tests++;
      if (bus.gpu_din !== e.din) begin
        n_fail++;
        $display("FAIL stream_din k=%0d got %h want %h", k, bus.gpu_din, e.din);
      end
      n_tests++;
      if (bus.bus_err !== e.err || bus.missed_frame !== e.miss) begin
        n_fail++;
        $display("FAIL stream_status k=%0d err=%b miss=%b want %b %b",
                 k, bus.bus_err, bus.missed_frame, e.err, e.miss);
      end
      n_tests++;
      if (bus.bus_req !== 1'b1 || bus.copy_start !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ctrl k=%0d req=%b start=%b busy=%b want 1 0 1",
                 k, bus.bus_req, bus.copy_start, bus.busy);
      end
      if (bus.mem_re === 1'b1) begin
        re_cnt++;
        last_addr = bus.mem_addr;
      end
      if (k == drop_at) bus.bus_gnt = 1'b0;
      if (k == vb_at)   bus.vblank_start = 1'b1;
      if (k == rst_at) begin
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.bus_req, bus.mem_re, bus.mem_addr, bus.copy_start, bus.gpu_din,
             bus.busy, bus.copy_done, bus.missed_frame, bus.bus_err} !== 49'd0) begin
          n_fail++;
          $display("FAIL midcopy_reset req=%b re=%b addr=%h din=%h busy=%b want all 0",
                   bus.bus_req, bus.mem_re, bus.mem_addr, bus.gpu_din, bus.busy);
        end
        bus.bus_gnt = 1'b0;
        step();
        reset = 1'b1;
        step();
        sb.delete();
        return;
      end
    end
    n_tests++;
    if (re_cnt != 5 * RC || last_addr !== BASE + 16'(5 * RC - 1)) begin
      n_fail++;
      $display("FAIL read_count count=%0d last=%h want %0d %h",
               re_cnt, last_addr, 5 * RC, BASE + 16'(5 * RC - 1));
    end
    step();
    n_tests++;
    if (bus.copy_done !== 1'b1 || bus.bus_req !== 1'b0 || bus.busy !== 1'b1 ||
        bus.mem_re !== 1'b0 || bus.gpu_din !== 16'h0) begin
      n_fail++;
      $display("FAIL done_cycle done=%b req=%b busy=%b re=%b din=%h want 1 0 1 0 0",
               bus.copy_done, bus.bus_req, bus.busy, bus.mem_re, bus.gpu_din);
    end
    bus.bus_gnt = 1'b0;
    step();
    n_tests++;
    if (bus.copy_done !== 1'b0 || bus.busy !== 1'b0 ||
        bus.bus_err !== (drop_at > 0)) begin
      n_fail++;
      $display("FAIL after_done done=%b busy=%b err=%b want 0 0 %b",
               bus.copy_done, bus.busy, bus.bus_err, drop_at > 0);
    end
  endtask

  task automatic test_copy();
    run_copy(-1, -1, -1);
  endtask

  task automatic test_missed_idle();
    bus.vblank_start = 1'b1;
    bus.frame_ready  = 1'b0;
    step();
    bus.vblank_start = 1'b0;
    n_tests++;
    if (bus.missed_frame !== 1'b1 || bus.busy !== 1'b0 || bus.bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL missed_idle miss=%b busy=%b req=%b want 1 0 0",
               bus.missed_frame, bus.busy, bus.bus_req);
    end
    step();
    n_tests++;
    if (bus.missed_frame !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL missed_idle_pulse miss=%b busy=%b want 0 0",
               bus.missed_frame, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    bus.vblank_start = 1'b1;
    bus.frame_ready  = 1'b1;
    bus.bus_gnt      = 1'b0;
    step();
    bus.vblank_start = 1'b0;
    while (bus.bus_req === 1'b1 && n < 300) begin
      n++;
      if (bus.missed_frame !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout_early_miss cycle=%0d got 1 want 0", n);
      end
      step();
    end
    n_tests++;
    if (n != 255) begin
      n_fail++;
      $display("FAIL timeout_req_cycles got %0d want 255", n);
    end
    n_tests++;
    if (bus.missed_frame !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_miss miss=%b busy=%b want 1 0", bus.missed_frame, bus.busy);
    end
    step();
    n_tests++;
    if (bus.missed_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_miss_pulse got %b want 0", bus.missed_frame);
    end
  endtask

  // Grant arriving in the very last REQ cycle must still start the copy.
  task automatic test_gnt_at_timeout();
    bus.vblank_start = 1'b1;
    bus.frame_ready  = 1'b1;
    bus.bus_gnt      = 1'b0;
    step();
    bus.vblank_start = 1'b0;
    for (int i = 2; i <= 255; i++) step();
    n_tests++;
    if (bus.bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_edge_req got %b want 1", bus.bus_req);
    end
    bus.bus_gnt = 1'b1;
    step();
    n_tests++;
    if (bus.copy_start !== 1'b1 || bus.missed_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL gnt_edge_start start=%b miss=%b want 1 0",
               bus.copy_start, bus.missed_frame);
    end
    do_reset();
  endtask

  task automatic test_bus_err();
    run_copy(100, 200, -1);
    do_reset();
    n_tests++;
    if (bus.bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bus_err_cleared got %b want 0", bus.bus_err);
    end
  endtask

  task automatic test_reset_midcopy();
    run_copy(-1, -1, 50);
    run_copy(-1, -1, -1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_copy();
    test_missed_idle();
    test_timeout();
    test_gnt_at_timeout();
    test_bus_err();
    test_reset_midcopy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
